hms_timekeeper: RTL and testbench

HMS_TIMEKEEPER -- requirements
Module: hms_timekeeper

---
 rtl/hms_timekeeper.sv | 144 ++++++++++++++
 tb/tb_hms_timekeeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper.sv
// Hour/minute/second timekeeper with a 1 s prescaler, 12/24 h display,
// field writes with range checking, and a minute-resolution alarm.
module hms_timekeeper #(
  parameter int unsigned TICK_DIV         = 50000000,
  parameter bit          ALARM_EN_DEFAULT = 1'b0
) (
  input  logic       clk_in_50M,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [1:0] set_sel,
  input  logic [6:0] set_value,
  input  logic [6:0] alarm_hour,
  input  logic [6:0] alarm_min,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hour,
  output logic       pm,
  output logic       tick,
  output logic       day_pulse,
  output logic       alarm_hit,
  output logic       set_err
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          armed_q, armed_d;
  logic          tick_q, tick_d;
  logic          day_q, day_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic          tickEdge;
  logic [4:0]    dispHour;

  assign tickEdge = en && (presc_q == PRESC_LAST);

  // A write always wins over a coincident tick edge; the tick is simply lost.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    armed_d = armed_q;
    tick_d  = 1'b0;
    day_d   = 1'b0;
    alarm_d = 1'b0;
    err_d   = 1'b0;

    if (en) begin
      presc_d = tickEdge ? '0 : presc_q + PW'(1);
    end

    if (set_valid) begin
      unique case (set_sel)
        2'b00: begin
          if (set_value < 7'd60) begin
            sec_d   = set_value[5:0];
            presc_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        2'b01: begin
          if (set_value < 7'd60) min_d = set_value[5:0];
          else                   err_d = 1'b1;
        end
        2'b10: begin
          if (set_value < 7'd24) hour_d = set_value[4:0];
          else                   err_d = 1'b1;
        end
        default: armed_d = set_value[0];
      endcase
    end else if (tickEdge) begin
      tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          if (hour_q == 5'd23) begin
            hour_d = '0;
            day_d  = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
      alarm_d = armed_q && ({2'b00, hour_d} == alarm_hour) &&
                ({1'b0, min_d} == alarm_min) && (sec_d == 6'd0);
    end
  end

  always_ff @(posedge clk_in_50M) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      armed_q <= ALARM_EN_DEFAULT;
      tick_q  <= 1'b0;
      day_q   <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      day_q   <= day_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  // Display hour follows mode_12h combinationally; midnight and noon show 12.
  always_comb begin
    dispHour = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0 || hour_q == 5'd12) dispHour = 5'd12;
      else if (hour_q > 5'd12)               dispHour = hour_q - 5'd12;
    end
  end

  assign sec       = {1'b0, sec_q};
  assign min       = {1'b0, min_q};
  assign hour      = {2'b00, dispHour};
  assign pm        = (hour_q >= 5'd12);
  assign tick      = tick_q;
  assign day_pulse = day_q;
  assign alarm_hit = alarm_q;
  assign set_err   = err_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Scoreboard bench for hms_timekeeper: a seconds-of-day reference model
// queues expected outputs, a monitor process compares them after each edge.
module tb_hms_timekeeper;

  localparam int TD = 4;

  typedef struct {
    int sec;
    int min;
    int hour;
    int pm;
    int tick;
    int day;
    int alarm;
    int err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0;
  logic       mode12 = 1'b0;
  logic       setValid = 1'b0;
  logic [1:0] setSel = 2'b00;
  logic [6:0] setValue = '0;
  logic [6:0] alarmHour = '0;
  logic [6:0] alarmMin = '0;
  logic [6:0] secO, minO, hourO;
  logic       pmO, tickO, dayO, alarmO, errO;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  // model state: time as seconds since midnight plus a prescaler count
  int   mTime = 0;
  int   mPresc = 0;
  int   mArmed = 0;

  hms_timekeeper #(.TICK_DIV(TD), .ALARM_EN_DEFAULT(1'b0)) dut (
    .clk_in_50M(clk),
    .rst_n(rstN),
    .en(en),
    .mode_12h(mode12),
    .set_valid(setValid),
    .set_sel(setSel),
    .set_value(setValue),
    .alarm_hour(alarmHour),
    .alarm_min(alarmMin),
    .sec(secO),
    .min(minO),
    .hour(hourO),
    .pm(pmO),
    .tick(tickO),
    .day_pulse(dayO),
    .alarm_hit(alarmO),
    .set_err(errO)
  );

  always #5 clk = ~clk;

  function automatic exp_t modelStep(input int r, input int e, input int m,
                                     input int sv, input int sel, input int val,
                                     input int ah, input int am);
    exp_t x;
    int   h;
    int   nextPresc;
    int   edgeHit;
    x.tick = 0; x.day = 0; x.alarm = 0; x.err = 0;
    if (r == 0) begin
      mTime = 0; mPresc = 0; mArmed = 0;
    end else begin
      edgeHit   = (e != 0) && (mPresc == TD - 1);
      nextPresc = (e != 0) ? (edgeHit ? 0 : mPresc + 1) : mPresc;
      if (sv != 0) begin
        case (sel)
          0: if (val < 60) begin
               mTime = mTime - (mTime % 60) + val;
               nextPresc = 0;
             end else x.err = 1;
          1: if (val < 60) mTime = (mTime / 3600) * 3600 + val * 60 + mTime % 60;
             else x.err = 1;
          2: if (val < 24) mTime = val * 3600 + mTime % 3600;
             else x.err = 1;
          default: mArmed = val % 2;
        endcase
      end else if (edgeHit) begin
        mTime  = (mTime + 1) % 86400;
        x.tick = 1;
        x.day  = (mTime == 0);
        x.alarm = (mArmed != 0) && ah < 24 && am < 60 && (mTime == ah * 3600 + am * 60);
      end
      mPresc = nextPresc;
    end
    h      = mTime / 3600;
    x.sec  = mTime % 60;
    x.min  = (mTime / 60) % 60;
    x.pm   = (h >= 12);
    x.hour = (m != 0) ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return x;
  endfunction

  task automatic applyStimulus(input int r, input int e, input int m, input int sv,
                               input int sel, input int val, input int ah, input int am);
    @(negedge clk);
    rstN      = r[0];
    en        = e[0];
    mode12    = m[0];
    setValid  = sv[0];
    setSel    = sel[1:0];
    setValue  = val[6:0];
    alarmHour = ah[6:0];
    alarmMin  = am[6:0];
    expQ.push_back(modelStep(r, e, m, sv, sel, val, ah, am));
  endtask

  task automatic checkOutput(input exp_t x);
    testsRun++;
    if (secO !== x.sec[6:0] || minO !== x.min[6:0] || hourO !== x.hour[6:0] ||
        pmO !== x.pm[0] || tickO !== x.tick[0] || dayO !== x.day[0] ||
        alarmO !== x.alarm[0] || errO !== x.err[0]) begin
      testsFailed++;
      $display("[TB] FAIL outputs @%0t: got %0d:%0d:%0d pm=%b tick=%b day=%b alarm=%b err=%b, want %0d:%0d:%0d pm=%0d tick=%0d day=%0d alarm=%0d err=%0d",
               $time, hourO, minO, secO, pmO, tickO, dayO, alarmO, errO,
               x.hour, x.min, x.sec, x.pm, x.tick, x.day, x.alarm, x.err);
    end
  endtask

  // monitor: outputs are presented every cycle, compare one entry per edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput(x);
      end
    end
  end

  task automatic run(input int n, input int e, input int m);
    for (int i = 0; i < n; i++) applyStimulus(1, e, m, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, input int val, input int m);
    applyStimulus(1, 1, m, 1, sel, val, 7, 30);
  endtask

  initial begin
    int r, e, m, sv, sel, val, ah, am, nt;
    // reset, then three ticks over twelve cycles
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    run(12, 1, 0);
    // full cascade at midnight
    wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
    run(5, 1, 0);
    // 12 h display
    wr(2, 0, 1); wr(2, 12, 1); wr(2, 13, 1); run(1, 1, 0);
    // range error, then write landing on the prescaler=3 edge
    wr(1, 60, 0); wr(2, 24, 0); wr(0, 99, 0);
    wr(0, 10, 0); run(3, 1, 0); wr(1, 5, 0); run(5, 1, 0);
    // alarm via tick, then no alarm via direct write
    wr(3, 127, 0); wr(2, 7, 0); wr(1, 29, 0); wr(0, 59, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 0, 7, 30);
    wr(1, 30, 0); wr(0, 0, 0); run(2, 1, 0);
    // out-of-range alarm never matches
    wr(1, 59, 0); wr(0, 59, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0, 7, 60);
    // hold with en=0, writes while held, reset mid-count
    run(2, 1, 0); run(10, 0, 0); applyStimulus(1, 0, 0, 1, 0, 20, 0, 0);
    run(3, 0, 1); run(2, 1, 0); applyStimulus(0, 1, 0, 1, 1, 5, 0, 0);
    run(5, 1, 1);
    // randomized traffic
    ah = 0; am = 0; m = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) m = $urandom_range(0, 1);
      sv = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 7) val = $urandom_range(0, (sel == 2) ? 23 : 59);
      else                          val = $urandom_range(0, 127);
      if ($urandom_range(0, 39) == 0) begin
        nt = ((mTime / 60) + 1) * 60 % 86400;
        ah = nt / 3600; am = (nt / 60) % 60;
      end else if ($urandom_range(0, 199) == 0) begin
        ah = $urandom_range(0, 127); am = $urandom_range(0, 127);
      end
      applyStimulus(r, e, m, sv, sel, val, ah, am);
    end
    @(posedge clk);
    #2;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d entries left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
